// File: rtl/bin_to_seg_display.sv
// Sequential binary-to-seven-segment converter: iterative double-dabble for decimal,
// direct nibble mapping for hex, with overflow dashes and optional leading-zero blanking.
module bin_to_seg_display #(
    parameter int W        = 8,
    parameter int D        = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     value,
    input  logic             hex_mode,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [4*D-1:0]   bcd,
    output logic [7*D-1:0]   seg
);

    localparam int         BW        = 4 * D;
    localparam int         XW        = (W > BW) ? W : BW;
    localparam logic [4:0] LAST_ITER = 5'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    shift_q;
    logic [BW-1:0]   scratch_q;
    logic            ovf_q;
    logic            hex_q;
    logic [4:0]      iter_q;

    logic [BW-1:0]   adj;
    logic [BW-1:0]   dd_bcd;
    logic [W-1:0]    dd_shift;
    logic            dd_carry;
    logic [XW-1:0]   value_ext;
    logic [BW-1:0]   hex_bcd;
    logic            hex_ovf;
    logic [7*D-1:0]  seg_n;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0:    seg_code = 7'b0111111;
            4'h1:    seg_code = 7'b0000110;
            4'h2:    seg_code = 7'b1011011;
            4'h3:    seg_code = 7'b1001111;
            4'h4:    seg_code = 7'b1100110;
            4'h5:    seg_code = 7'b1101101;
            4'h6:    seg_code = 7'b1111101;
            4'h7:    seg_code = 7'b0000111;
            4'h8:    seg_code = 7'b1111111;
            4'h9:    seg_code = 7'b1101111;
            4'hA:    seg_code = 7'b1110111;
            4'hB:    seg_code = 7'b1111100;
            4'hC:    seg_code = 7'b0111001;
            4'hD:    seg_code = 7'b1011110;
            4'hE:    seg_code = 7'b1111001;
            default: seg_code = 7'b1110001;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        // NOTE: assign every combinational output a default first so no path infers a latch.
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = CONV;
            CONV:    if (hex_q || iter_q == LAST_ITER) state_n = LOAD;
            LOAD:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, shift} left.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < D; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        {dd_carry, dd_bcd, dd_shift} = {adj, shift_q, 1'b0};
    end

    always_comb begin
        value_ext = XW'(shift_q);
        hex_bcd   = value_ext[BW-1:0];
        hex_ovf   = (value_ext >> BW) != '0;
    end

    // Scan from the top digit; zeros before the first nonzero digit go dark, digit 0 never does.
    always_comb begin : encode
        logic lead;
        seg_n = '0;
        lead  = 1'b1;
        for (int i = D - 1; i >= 0; i--) begin
            if (ovf_q) begin
                seg_n[7*i +: 7] = 7'b1000000;
            end else if (BLANK_LZ != 0 && lead && i != 0 && scratch_q[4*i +: 4] == 4'd0) begin
                seg_n[7*i +: 7] = 7'b0000000;
            end else begin
                seg_n[7*i +: 7] = seg_code(scratch_q[4*i +: 4]);
                lead            = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            hex_q     <= 1'b0;
            iter_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            bcd       <= '0;
            seg       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q   <= value;
                        hex_q     <= hex_mode;
                        scratch_q <= '0;
                        ovf_q     <= 1'b0;
                        iter_q    <= '0;
                        busy      <= 1'b1;
                    end
                end
                CONV: begin
                    if (hex_q) begin
                        scratch_q <= hex_bcd;
                        ovf_q     <= hex_ovf;
                    end else begin
                        scratch_q <= dd_bcd;
                        shift_q   <= dd_shift;
                        ovf_q     <= ovf_q | dd_carry;
                        iter_q    <= iter_q + 5'd1;
                    end
                end
                LOAD: begin
                    bcd      <= scratch_q;
                    seg      <= seg_n;
                    overflow <= ovf_q;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_seg_display.sv
// Self-checking bench: four converter instances (W=8) share stimulus and are compared
// against an arithmetic reference model of digit extraction, overflow and blanking.
module tb_bin_to_seg_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hex_mode = 1'b0;
    logic [7:0] value = 8'd0;

    logic        busy_a, done_a, ovf_a;  logic [11:0] bcd_a; logic [20:0] seg_a;
    logic        busy_b, done_b, ovf_b;  logic [11:0] bcd_b; logic [20:0] seg_b;
    logic        busy_c, done_c, ovf_c;  logic [7:0]  bcd_c; logic [13:0] seg_c;
    logic        busy_e, done_e, ovf_e;  logic [3:0]  bcd_e; logic [6:0]  seg_e;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [6:0] CODES [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    always #5 clk = ~clk;

    bin_to_seg_display #(.W(8), .D(3), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .hex_mode(hex_mode),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .bcd(bcd_a), .seg(seg_a));
    bin_to_seg_display #(.W(8), .D(3), .BLANK_LZ(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .hex_mode(hex_mode),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .bcd(bcd_b), .seg(seg_b));
    bin_to_seg_display #(.W(8), .D(2), .BLANK_LZ(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .hex_mode(hex_mode),
        .busy(busy_c), .done(done_c), .overflow(ovf_c), .bcd(bcd_c), .seg(seg_c));
    bin_to_seg_display #(.W(8), .D(1), .BLANK_LZ(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .hex_mode(hex_mode),
        .busy(busy_e), .done(done_e), .overflow(ovf_e), .bcd(bcd_e), .seg(seg_e));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Digits by repeated division in the chosen base; blanking from the most significant nonzero digit.
    function automatic void model(input int v, input bit h, input int d, input bit bl,
                                  output logic [19:0] eb, output logic [34:0] es, output logic eo);
        int base;
        int p;
        int msd;
        int dig [5];
        base = h ? 16 : 10;
        p    = 1;
        msd  = 0;
        eb   = '0;
        es   = '0;
        for (int i = 0; i < d; i++) begin
            dig[i] = (v / p) % base;
            p      = p * base;
        end
        eo = (v >= p);
        for (int i = 0; i < d; i++) begin
            eb[4*i +: 4] = 4'(dig[i]);
            if (dig[i] != 0) msd = i;
        end
        for (int i = 0; i < d; i++) begin
            if (eo)                 es[7*i +: 7] = 7'b1000000;
            else if (bl && i > msd) es[7*i +: 7] = 7'b0000000;
            else                    es[7*i +: 7] = CODES[dig[i]];
        end
    endfunction

    task automatic check_results(input string tag, input int v, input bit h);
        logic [19:0] eb;
        logic [34:0] es;
        logic        eo;
        model(v, h, 3, 1'b1, eb, es, eo);
        check({tag, " a.bcd"}, 64'(bcd_a), 64'(eb[11:0]));
        check({tag, " a.seg"}, 64'(seg_a), 64'(es[20:0]));
        check({tag, " a.ovf"}, 64'(ovf_a), 64'(eo));
        model(v, h, 3, 1'b0, eb, es, eo);
        check({tag, " b.bcd"}, 64'(bcd_b), 64'(eb[11:0]));
        check({tag, " b.seg"}, 64'(seg_b), 64'(es[20:0]));
        check({tag, " b.ovf"}, 64'(ovf_b), 64'(eo));
        model(v, h, 2, 1'b1, eb, es, eo);
        check({tag, " c.bcd"}, 64'(bcd_c), 64'(eb[7:0]));
        check({tag, " c.seg"}, 64'(seg_c), 64'(es[13:0]));
        check({tag, " c.ovf"}, 64'(ovf_c), 64'(eo));
        model(v, h, 1, 1'b1, eb, es, eo);
        check({tag, " e.bcd"}, 64'(bcd_e), 64'(eb[3:0]));
        check({tag, " e.seg"}, 64'(seg_e), 64'(es[6:0]));
        check({tag, " e.ovf"}, 64'(ovf_e), 64'(eo));
    endtask

    // Start at edge k; poke_a/poke_b re-assert start (value 12) just before edges k+poke.
    task automatic conv(input int v, input bit h, input int poke_a, input int poke_b);
        int n;
        n = h ? 1 : 8;
        @(negedge clk);
        value    = 8'(v);
        hex_mode = h;
        start    = 1'b1;
        for (int j = 0; j <= n + 4; j++) begin
            @(negedge clk);
            if (j + 1 == poke_a || j + 1 == poke_b) begin
                start = 1'b1;
                value = 8'd12;
            end else begin
                start = 1'b0;
                value = 8'($urandom);
            end
            hex_mode = 1'($urandom);
            if (j >= 1 && j <= n) begin
                check("busy during conversion", 64'(busy_a), 64'd1);
                check("no early done", 64'(done_a), 64'd0);
            end else if (j == n + 1) begin
                check("done pulse", 64'(done_a), 64'd1);
                check("busy drops with done", 64'(busy_a), 64'd0);
                check("done pulse on all", 64'({done_b, done_c, done_e}), 64'b111);
                check_results("result", v, h);
            end else if (j > n + 1) begin
                check("single done", 64'(done_a), 64'd0);
                check("idle not busy", 64'(busy_a), 64'd0);
            end
        end
        repeat (3) @(negedge clk);
        check_results("hold", v, h);
    endtask

    initial begin
        #12;
        check("reset busy", 64'(busy_a), 64'd0);
        check("reset done", 64'(done_a), 64'd0);
        check("reset ovf",  64'(ovf_a), 64'd0);
        check("reset bcd",  64'(bcd_a), 64'd0);
        check("reset seg",  64'({seg_a, seg_b, seg_c, seg_e}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        conv(255, 1'b0, 0, 0);
        check("dec 255 bcd", 64'(bcd_a), 64'h255);
        check("dec 255 seg", 64'(seg_a), 64'({7'b1011011, 7'b1101101, 7'b1101101}));

        conv(0, 1'b0, 0, 0);
        check("blank zero", 64'(seg_a), 64'({7'b0000000, 7'b0000000, 7'b0111111}));
        conv(7, 1'b0, 0, 0);
        check("blank seven", 64'(seg_a), 64'({7'b0000000, 7'b0000000, 7'b0000111}));
        check("no blank seven", 64'(seg_b), 64'({7'b0111111, 7'b0111111, 7'b0000111}));

        conv(100, 1'b0, 0, 0);
        check("d2 ovf 100", 64'(ovf_c), 64'd1);
        check("d2 dashes", 64'(seg_c), 64'({7'b1000000, 7'b1000000}));
        conv(99, 1'b0, 0, 0);
        check("d2 99 ovf", 64'(ovf_c), 64'd0);
        check("d2 99 seg", 64'(seg_c), 64'({7'b1101111, 7'b1101111}));

        conv(8'hAF, 1'b1, 0, 0);
        check("hex AF seg", 64'(seg_a), 64'({7'b0000000, 7'b1110111, 7'b1110001}));
        conv(8'h1F, 1'b1, 0, 0);
        check("d1 hex ovf", 64'(ovf_e), 64'd1);
        check("d1 hex dash", 64'(seg_e), 64'(7'b1000000));

        conv(200, 1'b0, 3, 9);
        check("ignored starts bcd", 64'(bcd_a), 64'h200);

        for (int r = 0; r < 24; r++) begin
            conv(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, 0);
        end

        // Abort a decimal conversion at k+4 and confirm the outputs go dark at once.
        @(negedge clk);
        value    = 8'd200;
        hex_mode = 1'b0;
        start    = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy_a), 64'd0);
        check("abort done", 64'(done_a), 64'd0);
        check("abort bcd",  64'(bcd_a), 64'd0);
        check("abort seg",  64'({seg_a, seg_b, seg_c, seg_e}), 64'd0);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("no done after abort", 64'({done_a, done_b, done_c, done_e}), 64'd0);
        end
        rst_n = 1'b1;
        conv(42, 1'b0, 0, 0);
        check("after reset bcd", 64'(bcd_a), 64'h042);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
